kb_scan_parser: RTL and testbench
=================================

# kb_scan_parser

Sequencer between the PS/2 byte receiver and the game key decoder. Consumes raw scan-code bytes (scan code set 2) and turns multi-byte make/break sequences into single key events. Each event drives `code_new`/`key_pressed`/`key_code` into the W/A/S/D key-state decoder. Handles the `E0` (extended) and `F0` (break) prefixes, skips the 8-byte Pause sequence, filters controller status bytes, suppresses typematic repeats and recovers from truncated sequences by timeout.

## Interface
- TIMEOUT_CYCLES, 100000, idle cycles allowed between bytes of one sequence before abort (≥2)
- SUPPRESS_REPEAT, 1, 1 = drop repeated make of the key currently held; 0 = forward every make
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high; clock clk
- rx_done  in  1  one-cycle strobe, rx_data valid
- rx_data  in  8  received scan byte
- code_new  out  1  one-cycle pulse, key event valid
- key_pressed  out  1  1 = make, 0 = break; held until next event
- key_code  out  8  final scan byte of the event; held until next event
- key_extended  out  1  event carried the E0 prefix; held until next event
- proto_err  out  1  one-cycle pulse on illegal prefix order or timeout

## Operation
- FSM states: IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 F0 seen), SKIP (Pause sequence).
- Bytes are processed only on cycles with rx_done=1. The state is otherwise unchanged, apart from the timeout.
- IDLE:
  - E0 -> EXT.
  - F0 -> BRK.
  - E1 -> SKIP with skip_cnt=7.
  - Status bytes 00, AA, EE, FA, FC, FE, FF are ignored and stay in IDLE.
  - Any other byte is a make event (code=byte, ext=0) and stays in IDLE.
- EXT:
  - F0 -> EXT_BRK.
  - E0 or E1 -> proto_err, IDLE.
  - Any other byte is a make event with ext=1, then IDLE.
- BRK:
  - E0, E1 or F0 -> proto_err, IDLE.
  - Any other byte is a break event with ext=0, then IDLE.
- EXT_BRK:
  - E0, E1 or F0 -> proto_err, IDLE.
  - Any other byte is a break event with ext=1, then IDLE.
- SKIP:
  - Each byte decrements skip_cnt.
  - The byte that finds skip_cnt==1 returns the FSM to IDLE.
  - No events are generated, and byte values are not checked.
- Repeat filter (SUPPRESS_REPEAT=1):
  - Registers held_code[7:0], held_ext, held_valid.
  - A make that matches {held_ext, held_code} while held_valid=1 produces no event.
  - Any other make emits an event and loads held_* with held_valid=1.
  - A break that matches the held key clears held_valid.
  - Every break emits an event.
- Timeout:
  - Counter width is ceil(log2(TIMEOUT_CYCLES)).
  - It counts every cycle the FSM is outside IDLE and clears on every rx_done and in IDLE.
  - When the count reaches TIMEOUT_CYCLES-1 with no rx_done: FSM -> IDLE, proto_err pulses, and the partial sequence is discarded without emitting an event.
- Simultaneous rx_done and timeout expiry: the byte wins. It is processed in the current state and the counter clears.
- proto_err and code_new never assert in the same cycle.

## Timing
- Reset values:
  - code_new=0, key_pressed=0, key_code=8'h00, key_extended=0, proto_err=0.
  - FSM=IDLE, skip_cnt=0, timeout counter=0, held_valid=0, held_code=0, held_ext=0.
- Latency: the final byte's rx_done is at cycle N. code_new is high at cycle N+1 only. key_pressed, key_code and key_extended update in the same cycle and then hold.
- proto_err: pulse at N+1 for an illegal byte at N. For a timeout, pulse on the cycle after the count reaches TIMEOUT_CYCLES-1.
- Back-to-back rx_done on consecutive cycles is supported with no byte lost; one event per completing byte.
- All outputs are registered; no combinational path from rx_* to outputs.
- Reset mid-sequence (including SKIP) aborts it immediately; no event or error is emitted at deassertion.

## Test plan
- Byte 1D -> code_new pulse 1 cycle later with key_pressed=1, key_code=1D, key_extended=0. Then bytes F0, 1D -> one pulse with key_pressed=0, key_code=1D.
- Bytes E0 75, then E0 F0 75 -> make then break events, both with key_extended=1 and key_code=75. No event on the prefix bytes.
- 1C sent three times, then F0 1C, then 1C again, with SUPPRESS_REPEAT=1 -> events: make, break, make (3 total). With SUPPRESS_REPEAT=0 -> 5 events.
- Pause sequence E1 14 77 E1 F0 14 F0 77, then 23 -> exactly one event (make 23). Bytes AA and FA in IDLE -> no event.
- F0, then silence for TIMEOUT_CYCLES (test value 16) -> proto_err single pulse, FSM back in IDLE. A following 1B gives a make event, not a break. F0 then E0 -> proto_err, no event.
- Assert reset after E0 F0, deassert, send 1D -> make event with ext=0. All outputs are 0 during reset.

Source files
------------

// File: rtl/kb_scan_parser.sv
// kb_scan_parser
// Turns PS/2 scan code set 2 byte sequences into single key events.
// Handles E0 (extended) and F0 (break) prefixes, skips the E1 Pause
// sequence, drops controller status bytes, optionally suppresses
// typematic repeats of the held key, and aborts stalled sequences.
module kb_scan_parser #(
  parameter int unsigned TIMEOUT_CYCLES  = 100000,
  parameter bit          SUPPRESS_REPEAT = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_done,
  input  logic [7:0] rx_data,
  output logic       code_new,
  output logic       key_pressed,
  output logic [7:0] key_code,
  output logic       key_extended,
  output logic       proto_err
);

  // Sequence states
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_EXT     = 3'd1;
  localparam logic [2:0] S_BRK     = 3'd2;
  localparam logic [2:0] S_EXT_BRK = 3'd3;
  localparam logic [2:0] S_SKIP    = 3'd4;

  // Prefix and special bytes
  localparam logic [7:0] B_EXT   = 8'hE0;
  localparam logic [7:0] B_BRK   = 8'hF0;
  localparam logic [7:0] B_PAUSE = 8'hE1;

  // Bytes remaining after the E1 that opens the Pause sequence
  localparam logic [2:0] PAUSE_TAIL = 3'd7;

  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  // Sequencer state
  logic [2:0]    state_q, state_d;
  logic [2:0]    skip_cnt_q, skip_cnt_d;
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;

  // Repeat filter
  logic [7:0]    held_code_q, held_code_d;
  logic          held_ext_q, held_ext_d;
  logic          held_valid_q, held_valid_d;

  // Registered outputs
  logic          code_new_q, code_new_d;
  logic          key_pressed_q, key_pressed_d;
  logic [7:0]    key_code_q, key_code_d;
  logic          key_extended_q, key_extended_d;
  logic          proto_err_q, proto_err_d;

  // Byte classification and pending event from the sequencer
  logic          is_status;
  logic          is_prefix;
  logic          emit;
  logic          emit_make;
  logic          emit_ext;
  logic          held_match;

  // Classify the incoming byte
  always_comb begin
    is_status = 1'b0;
    case (rx_data)
      8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF: is_status = 1'b1;
      default:                                          is_status = 1'b0;
    endcase
    is_prefix = (rx_data == B_EXT) || (rx_data == B_BRK) || (rx_data == B_PAUSE);
  end

  // Sequencer: state transitions, skip/timeout counters, raw event decode
  always_comb begin
    state_d     = state_q;
    skip_cnt_d  = skip_cnt_q;
    tmo_cnt_d   = tmo_cnt_q;
    proto_err_d = 1'b0;
    emit        = 1'b0;
    emit_make   = 1'b0;
    emit_ext    = 1'b0;

    if (rx_done) begin
      // A byte always wins over a coincident timeout expiry.
      tmo_cnt_d = '0;
      case (state_q)
        S_IDLE: begin
          if (rx_data == B_EXT) begin
            state_d = S_EXT;
          end else if (rx_data == B_BRK) begin
            state_d = S_BRK;
          end else if (rx_data == B_PAUSE) begin
            state_d    = S_SKIP;
            skip_cnt_d = PAUSE_TAIL;
          end else if (!is_status) begin
            emit      = 1'b1;
            emit_make = 1'b1;
          end
        end
        S_EXT: begin
          if (rx_data == B_BRK) begin
            state_d = S_EXT_BRK;
          end else if (rx_data == B_EXT || rx_data == B_PAUSE) begin
            state_d     = S_IDLE;
            proto_err_d = 1'b1;
          end else begin
            state_d   = S_IDLE;
            emit      = 1'b1;
            emit_make = 1'b1;
            emit_ext  = 1'b1;
          end
        end
        S_BRK, S_EXT_BRK: begin
          state_d = S_IDLE;
          if (is_prefix) begin
            proto_err_d = 1'b1;
          end else begin
            emit     = 1'b1;
            emit_ext = (state_q == S_EXT_BRK);
          end
        end
        S_SKIP: begin
          skip_cnt_d = skip_cnt_q - 3'd1;
          if (skip_cnt_q == 3'd1) begin
            state_d = S_IDLE;
          end
        end
        default: begin
          state_d    = S_IDLE;
          skip_cnt_d = '0;
        end
      endcase
    end else if (state_q != S_IDLE) begin
      if (tmo_cnt_q == TMO_LAST) begin
        state_d     = S_IDLE;
        skip_cnt_d  = '0;
        tmo_cnt_d   = '0;
        proto_err_d = 1'b1;
      end else begin
        tmo_cnt_d = tmo_cnt_q + 1'b1;
      end
    end else begin
      tmo_cnt_d = '0;
    end
  end

  // Repeat filter and output event formation
  always_comb begin
    held_code_d    = held_code_q;
    held_ext_d     = held_ext_q;
    held_valid_d   = held_valid_q;
    code_new_d     = 1'b0;
    key_pressed_d  = key_pressed_q;
    key_code_d     = key_code_q;
    key_extended_d = key_extended_q;
    held_match     = held_valid_q && (held_code_q == rx_data) && (held_ext_q == emit_ext);

    if (emit) begin
      if (emit_make) begin
        if (!(SUPPRESS_REPEAT && held_match)) begin
          code_new_d     = 1'b1;
          key_pressed_d  = 1'b1;
          key_code_d     = rx_data;
          key_extended_d = emit_ext;
          held_code_d    = rx_data;
          held_ext_d     = emit_ext;
          held_valid_d   = 1'b1;
        end
      end else begin
        if (held_match) begin
          held_valid_d = 1'b0;
        end
        code_new_d     = 1'b1;
        key_pressed_d  = 1'b0;
        key_code_d     = rx_data;
        key_extended_d = emit_ext;
      end
    end
  end

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= S_IDLE;
      skip_cnt_q     <= '0;
      tmo_cnt_q      <= '0;
      held_code_q    <= '0;
      held_ext_q     <= 1'b0;
      held_valid_q   <= 1'b0;
      code_new_q     <= 1'b0;
      key_pressed_q  <= 1'b0;
      key_code_q     <= '0;
      key_extended_q <= 1'b0;
      proto_err_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      skip_cnt_q     <= skip_cnt_d;
      tmo_cnt_q      <= tmo_cnt_d;
      held_code_q    <= held_code_d;
      held_ext_q     <= held_ext_d;
      held_valid_q   <= held_valid_d;
      code_new_q     <= code_new_d;
      key_pressed_q  <= key_pressed_d;
      key_code_q     <= key_code_d;
      key_extended_q <= key_extended_d;
      proto_err_q    <= proto_err_d;
    end
  end

  assign code_new     = code_new_q;
  assign key_pressed  = key_pressed_q;
  assign key_code     = key_code_q;
  assign key_extended = key_extended_q;
  assign proto_err    = proto_err_q;

endmodule

// File: tb/tb_kb_scan_parser.sv
// Testbench for kb_scan_parser: two instances (repeat suppression on/off)
// share one byte stream and are compared every cycle against a
// sequence-level reference model.
module tb_kb_scan_parser;

  localparam int unsigned TMO = 16;

  logic       clk;
  logic       reset;
  logic       rx_done;
  logic [7:0] rx_data;

  logic       code_new_s, key_pressed_s, key_extended_s, proto_err_s;
  logic [7:0] key_code_s;
  logic       code_new_n, key_pressed_n, key_extended_n, proto_err_n;
  logic [7:0] key_code_n;

  kb_scan_parser #(.TIMEOUT_CYCLES(TMO), .SUPPRESS_REPEAT(1'b1)) dut_s (
    .clk(clk), .reset(reset), .rx_done(rx_done), .rx_data(rx_data),
    .code_new(code_new_s), .key_pressed(key_pressed_s), .key_code(key_code_s),
    .key_extended(key_extended_s), .proto_err(proto_err_s)
  );

  kb_scan_parser #(.TIMEOUT_CYCLES(TMO), .SUPPRESS_REPEAT(1'b0)) dut_n (
    .clk(clk), .reset(reset), .rx_done(rx_done), .rx_data(rx_data),
    .code_new(code_new_n), .key_pressed(key_pressed_n), .key_code(key_code_n),
    .key_extended(key_extended_n), .proto_err(proto_err_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned checks;
  int unsigned failures;

  // Reference model: pending prefixes, skip bytes left, quiet cycles
  bit          pend_ext, pend_brk;
  int unsigned skip_left;
  int unsigned quiet;
  // Per-instance (0 = suppress on, 1 = suppress off) expected outputs
  bit          sup[2];
  bit          held_v[2];
  logic [8:0]  held[2];
  logic        exp_new[2], exp_pressed[2], exp_ext[2];
  logic [7:0]  exp_code[2];
  logic        exp_err;
  int unsigned ev_cnt[2];

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    pend_ext = 0; pend_brk = 0; skip_left = 0; quiet = 0; exp_err = 0;
    for (int k = 0; k < 2; k++) begin
      held_v[k] = 0; held[k] = '0;
      exp_new[k] = 0; exp_pressed[k] = 0; exp_ext[k] = 0; exp_code[k] = '0;
    end
  endtask

  task automatic model_event(input bit make, input logic [7:0] b, input bit e);
    for (int k = 0; k < 2; k++) begin
      if (make && sup[k] && held_v[k] && held[k] == {e, b}) continue;
      if (make) begin
        held[k] = {e, b}; held_v[k] = 1;
      end else if (held_v[k] && held[k] == {e, b}) begin
        held_v[k] = 0;
      end
      exp_new[k] = 1; exp_pressed[k] = make; exp_code[k] = b; exp_ext[k] = e;
    end
  endtask

  task automatic model_abort();
    pend_ext = 0; pend_brk = 0; skip_left = 0; exp_err = 1;
  endtask

  task automatic model_byte(input logic [7:0] b);
    bit pfx;
    quiet = 0;
    pfx = (b == 8'hE0) || (b == 8'hF0) || (b == 8'hE1);
    if (skip_left > 0) begin
      skip_left--;
    end else if (!pend_ext && !pend_brk) begin
      if (b == 8'hE0) pend_ext = 1;
      else if (b == 8'hF0) pend_brk = 1;
      else if (b == 8'hE1) skip_left = 7;
      else if (!(b inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF}))
        model_event(1, b, 0);
    end else if (!pend_brk) begin
      if (b == 8'hF0) pend_brk = 1;
      else if (pfx) model_abort();
      else begin pend_ext = 0; model_event(1, b, 1); end
    end else begin
      if (pfx) model_abort();
      else begin model_event(0, b, pend_ext); pend_ext = 0; pend_brk = 0; end
    end
  endtask

  task automatic model_quiet();
    if (pend_ext || pend_brk || skip_left > 0) begin
      quiet++;
      if (quiet == TMO) begin model_abort(); quiet = 0; end
    end else begin
      quiet = 0;
    end
  endtask

  task automatic compare(input string ctx);
    chk({ctx, " code_new_s"},     {7'd0, code_new_s},     {7'd0, exp_new[0]});
    chk({ctx, " key_pressed_s"},  {7'd0, key_pressed_s},  {7'd0, exp_pressed[0]});
    chk({ctx, " key_code_s"},     key_code_s,             exp_code[0]);
    chk({ctx, " key_extended_s"}, {7'd0, key_extended_s}, {7'd0, exp_ext[0]});
    chk({ctx, " proto_err_s"},    {7'd0, proto_err_s},    {7'd0, exp_err});
    chk({ctx, " code_new_n"},     {7'd0, code_new_n},     {7'd0, exp_new[1]});
    chk({ctx, " key_pressed_n"},  {7'd0, key_pressed_n},  {7'd0, exp_pressed[1]});
    chk({ctx, " key_code_n"},     key_code_n,             exp_code[1]);
    chk({ctx, " key_extended_n"}, {7'd0, key_extended_n}, {7'd0, exp_ext[1]});
    chk({ctx, " proto_err_n"},    {7'd0, proto_err_n},    {7'd0, exp_err});
    if (code_new_s === 1'b1) ev_cnt[0]++;
    if (code_new_n === 1'b1) ev_cnt[1]++;
  endtask

  // One clock cycle: drive (or not) a byte, advance model, check outputs
  task automatic step(input string ctx, input logic v, input logic [7:0] d);
    rx_done = v; rx_data = d;
    exp_new[0] = 0; exp_new[1] = 0; exp_err = 0;
    if (v) model_byte(d); else model_quiet();
    @(posedge clk); #1;
    compare(ctx);
  endtask

  task automatic send(input string ctx, input logic [7:0] b);
    step(ctx, 1'b1, b);
  endtask

  task automatic idle(input string ctx, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) step(ctx, 1'b0, 8'h00);
  endtask

  task automatic clr_counts();
    ev_cnt[0] = 0; ev_cnt[1] = 0;
  endtask

  initial begin
    logic [7:0] pool [12];
    int unsigned tmo_edge;
    checks = 0; failures = 0;
    sup[0] = 1; sup[1] = 0;
    pool = '{8'hE0, 8'hF0, 8'hE1, 8'hAA, 8'hFA, 8'h1C, 8'h1D, 8'h75, 8'h23, 8'h6B, 8'h14, 8'hF0};
    model_reset();
    reset = 1; rx_done = 0; rx_data = '0;
    @(posedge clk); #1;
    // Outputs at reset
    compare("reset");
    reset = 0;
    idle("post_reset", 2);

    // Plain make then break
    send("make_1d", 8'h1D);
    send("brk_f0", 8'hF0);
    send("brk_1d", 8'h1D);
    idle("gap", 2);

    // Extended make / break
    send("ext_e0", 8'hE0);
    send("ext_75", 8'h75);
    send("extb_e0", 8'hE0);
    send("extb_f0", 8'hF0);
    send("extb_75", 8'h75);
    idle("gap", 1);

    // Typematic repeat filter, back-to-back bytes
    clr_counts();
    send("rep1", 8'h1C); send("rep2", 8'h1C); send("rep3", 8'h1C);
    send("rep_f0", 8'hF0); send("rep_brk", 8'h1C); send("rep_again", 8'h1C);
    idle("gap", 1);
    chk("repeat_events_s", 8'(ev_cnt[0]), 8'd3);
    chk("repeat_events_n", 8'(ev_cnt[1]), 8'd5);

    // Pause sequence and status bytes
    send("brk_1c", 8'hF0); send("brk_1c", 8'h1C);
    clr_counts();
    send("pause", 8'hE1); send("pause", 8'h14); send("pause", 8'h77); send("pause", 8'hE1);
    send("pause", 8'hF0); send("pause", 8'h14); send("pause", 8'hF0); send("pause", 8'h77);
    send("after_pause", 8'h23);
    send("status_aa", 8'hAA);
    send("status_fa", 8'hFA);
    idle("gap", 2);
    chk("pause_events_s", 8'(ev_cnt[0]), 8'd1);
    chk("pause_events_n", 8'(ev_cnt[1]), 8'd1);

    // Timeout: error exactly TMO quiet cycles after F0
    send("tmo_f0", 8'hF0);
    tmo_edge = 0;
    for (int unsigned i = 1; i <= TMO + 4; i++) begin
      step("tmo_wait", 1'b0, 8'h00);
      if (proto_err_s === 1'b1 && tmo_edge == 0) tmo_edge = i;
    end
    chk("tmo_latency", 8'(tmo_edge), 8'(TMO));
    send("tmo_then_1b", 8'h1B);
    // Byte arriving on the expiry cycle wins
    send("race_f0", 8'hF0);
    idle("race_wait", TMO - 1);
    send("race_1d", 8'h1D);
    // Illegal prefix order
    send("bad_f0", 8'hF0);
    send("bad_e0", 8'hE0);
    idle("gap", 2);

    // Reset mid-sequence
    send("rst_e0", 8'hE0);
    send("rst_f0", 8'hF0);
    reset = 1;
    model_reset();
    @(posedge clk); #1;
    compare("in_reset");
    reset = 0;
    send("rst_1d", 8'h1D);
    idle("gap", 2);

    // Random byte stream with random gaps
    for (int unsigned n = 0; n < 400; n++) begin
      send("rand", pool[$urandom_range(0, 11)]);
      if ($urandom_range(0, 15) == 0) idle("rand_long", $urandom_range(TMO - 2, TMO + 3));
      else idle("rand_gap", $urandom_range(0, 3));
    end
    idle("drain", TMO + 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
